// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
//   Decode -> execute pipeline register with load-use hazard detection.
//   Captures the decoded control bundle, operands, immediate, PC+2 and the
//   destination register every clock. Inserts a bubble when execute holds a
//   load whose destination is read by the instruction in decode, honours an
//   external hold (stall_in) and squash (flush_in), and stops accepting new
//   work once a HALT has entered execute.
//
//   Optional feature macro: ID_EX_HAZARD_EN
//     defined   : load-use detection active, stall_out driven.
//     undefined : load_use is 0, stall_out tied 0 (software avoids hazards).
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     stall_in, flush_in   hold all state / load a bubble next edge
//     id_valid             decode slot holds a real instruction
//     ctrl_in              decoded control ([0] reg_write, [1] mem_write,
//                          [2] mem_read, [3] halt, [4] err, [5] jump,
//                          [8:6] branchSel, rest opaque)
//     rs_in, rt_in         source register numbers
//     use_rs, use_rt       instruction really reads rs / rt
//     dest_in              resolved write register
//     rd1_in .. pc2_in     operands, extended immediate, PC+2
//     ex_valid .. pc2_out  registered execute-stage bundle
//     stall_out            combinational: hold PC and IF/ID this cycle
//     halted               sticky: a HALT has entered execute
// -----------------------------------------------------------------------------
module id_ex_reg #(
  parameter int CTRL_W = 30,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [2:0]        rs_in,
  input  logic [2:0]        rt_in,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic [2:0]        dest_in,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [DATA_W-1:0] pc2_in,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [2:0]        dest_out,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] pc2_out,
  output logic              stall_out,
  output logic              halted
);

  localparam int B_REG_WRITE = 0;
  localparam int B_MEM_WRITE = 1;
  localparam int B_MEM_READ  = 2;
  localparam int B_HALT      = 3;

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [2:0]        r_dest;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc2;
  logic              r_halted;

  logic              w_valid;
  logic [CTRL_W-1:0] w_ctrl;
  logic [2:0]        w_dest;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_pc2;
  logic              w_halted;

  logic              w_load_use;

`ifdef ID_EX_HAZARD_EN
  logic w_ex_load;
  logic w_rs_hit;
  logic w_rt_hit;

  // A real load only: stores (no reg_write) and store-update (mem_write) are
  // excluded because neither leaves a late result in the register file.
  always_comb begin
    w_ex_load  = r_valid & r_ctrl[B_MEM_READ] & r_ctrl[B_REG_WRITE] & ~r_ctrl[B_MEM_WRITE];
    w_rs_hit   = use_rs & (rs_in == r_dest);
    w_rt_hit   = use_rt & (rt_in == r_dest);
    w_load_use = w_ex_load & id_valid & (w_rs_hit | w_rt_hit);
  end

  // Flush squashes the decode slot, so holding it would be pointless; once
  // halted nothing new is accepted so upstream need not be held either.
  always_comb begin
    stall_out = w_load_use & ~flush_in & ~r_halted;
  end
`else
  // Hazard detection compiled out: never bubble, never hold upstream.
  always_comb begin
    w_load_use = 1'b0;
    stall_out  = 1'b0;
  end
`endif

  // Next-state selection: flush > stall_in > halted > load_use > capture.
  always_comb begin
    // default: hold everything
    w_valid  = r_valid;
    w_ctrl   = r_ctrl;
    w_dest   = r_dest;
    w_rd1    = r_rd1;
    w_rd2    = r_rd2;
    w_imm    = r_imm;
    w_pc2    = r_pc2;
    w_halted = r_halted;
    if (flush_in) begin
      w_valid = 1'b0;
      w_ctrl  = '0;
      w_dest  = 3'd0;
      w_rd1   = '0;
      w_rd2   = '0;
      w_imm   = '0;
      w_pc2   = '0;
    end else if (stall_in) begin
      w_valid = r_valid;
    end else if (r_halted || w_load_use) begin
      w_valid = 1'b0;
      w_ctrl  = '0;
      w_dest  = 3'd0;
      w_rd1   = '0;
      w_rd2   = '0;
      w_imm   = '0;
      w_pc2   = '0;
    end else begin
      w_valid  = id_valid;
      // an empty decode slot must not carry side-effecting control bits
      w_ctrl   = id_valid ? ctrl_in : '0;
      w_dest   = dest_in;
      w_rd1    = rd1_in;
      w_rd2    = rd2_in;
      w_imm    = imm_in;
      w_pc2    = pc2_in;
      w_halted = r_halted | (id_valid & ctrl_in[B_HALT]);
    end
  end

  // Pipeline state register with asynchronous clear to a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_dest   <= 3'd0;
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_imm    <= '0;
      r_pc2    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_valid  <= w_valid;
      r_ctrl   <= w_ctrl;
      r_dest   <= w_dest;
      r_rd1    <= w_rd1;
      r_rd2    <= w_rd2;
      r_imm    <= w_imm;
      r_pc2    <= w_pc2;
      r_halted <= w_halted;
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    ex_valid = r_valid;
    ctrl_out = r_ctrl;
    dest_out = r_dest;
    rd1_out  = r_rd1;
    rd2_out  = r_rd2;
    imm_out  = r_imm;
    pc2_out  = r_pc2;
    halted   = r_halted;
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg
//   Directed bench for id_ex_reg. Expectations depend on whether
//   ID_EX_HAZARD_EN is defined for the build (HZ below).
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

`ifdef ID_EX_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        stall_in;
  logic        flush_in;
  logic        id_valid;
  logic [29:0] ctrl_in;
  logic [2:0]  rs_in;
  logic [2:0]  rt_in;
  logic        use_rs;
  logic        use_rt;
  logic [2:0]  dest_in;
  logic [15:0] rd1_in;
  logic [15:0] rd2_in;
  logic [15:0] imm_in;
  logic [15:0] pc2_in;
  logic        ex_valid;
  logic [29:0] ctrl_out;
  logic [2:0]  dest_out;
  logic [15:0] rd1_out;
  logic [15:0] rd2_out;
  logic [15:0] imm_out;
  logic [15:0] pc2_out;
  logic        stall_out;
  logic        halted;

  int n_checks;
  int n_errors;

  id_ex_reg #(.CTRL_W(30), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .id_valid(id_valid), .ctrl_in(ctrl_in), .rs_in(rs_in), .rt_in(rt_in),
    .use_rs(use_rs), .use_rt(use_rt), .dest_in(dest_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in), .pc2_in(pc2_in),
    .ex_valid(ex_valid), .ctrl_out(ctrl_out), .dest_out(dest_out),
    .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out), .pc2_out(pc2_out),
    .stall_out(stall_out), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [29:0] c, input logic [2:0] d, input logic [2:0] rs,
                       input logic urs, input logic [2:0] rt, input logic urt,
                       input logic [15:0] r1);
    ctrl_in = c; dest_in = d; rs_in = rs; use_rs = urs; rt_in = rt; use_rt = urt;
    rd1_in = r1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; stall_in = 1'b0; flush_in = 1'b0; id_valid = 1'b0;
    ctrl_in = 30'd0; rs_in = 3'd0; rt_in = 3'd0; use_rs = 1'b0; use_rt = 1'b0;
    dest_in = 3'd0; rd1_in = 16'd0; rd2_in = 16'd0; imm_in = 16'd0; pc2_in = 16'd0;
    #2;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_ctrl", 32'(ctrl_out), 32'd0);
    chk("rst_rd1", 32'(rd1_out), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // ADDI r3, rd1=5
    id_valid = 1'b1;
    drive(30'h1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0005);
    rd2_in = 16'h0007; imm_in = 16'h0009; pc2_in = 16'h0102;
    tick();
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_dest", 32'(dest_out), 32'd3);
    chk("addi_rd1", 32'(rd1_out), 32'h5);
    chk("addi_imm", 32'(imm_out), 32'h9);
    chk("addi_pc2", 32'(pc2_out), 32'h0102);

    // asynchronous reset mid-cycle
    #3; rst_n = 1'b0; #1;
    chk("async_valid", 32'(ex_valid), 32'd0);
    chk("async_rd1", 32'(rd1_out), 32'd0);
    chk("async_dest", 32'(dest_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // LD r2, then ADD reading r2 through rs
    drive(30'h5, 3'd2, 3'd1, 1'b1, 3'd0, 1'b0, 16'h0020);
    #1;
    chk("ld_stall", 32'(stall_out), 32'd0);
    tick();
    chk("ld_ctrl", 32'(ctrl_out), 32'h5);
    chk("ld_dest", 32'(dest_out), 32'd2);
    drive(30'h1, 3'd5, 3'd2, 1'b1, 3'd4, 1'b1, 16'h0011);
    #1;
    chk("lu_rs_stall", 32'(stall_out), 32'(HZ));
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), HZ ? 32'd0 : 32'd1);
    chk("lu_bubble_dest", 32'(dest_out), HZ ? 32'd0 : 32'd5);
    chk("lu_after_stall", 32'(stall_out), 32'd0);
    tick();
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_dest", 32'(dest_out), 32'd5);
    chk("add_rd1", 32'(rd1_out), 32'h11);

    // STU to r2 then reader of r2: no hazard
    drive(30'h7, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0000);
    tick();
    drive(30'h1, 3'd6, 3'd2, 1'b1, 3'd0, 1'b0, 16'h0033);
    #1;
    chk("stu_stall", 32'(stall_out), 32'd0);
    tick();
    chk("stu_reader", 32'(dest_out), 32'd6);

    // ST (mem_read without reg_write) then reader of r2: no hazard
    drive(30'h4, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0000);
    tick();
    drive(30'h1, 3'd6, 3'd2, 1'b1, 3'd0, 1'b0, 16'h0033);
    #1;
    chk("st_stall", 32'(stall_out), 32'd0);
    tick();
    chk("st_reader", 32'(dest_out), 32'd6);

    // LD r2 then an instruction naming r2 but not reading it
    drive(30'h5, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0000);
    tick();
    drive(30'h1, 3'd6, 3'd2, 1'b0, 3'd2, 1'b0, 16'h0033);
    #1;
    chk("nouse_stall", 32'(stall_out), 32'd0);
    tick();
    chk("nouse_reader", 32'(dest_out), 32'd6);

    // LD r2, reader via rt under stall_in, then flush on top
    drive(30'h5, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0044);
    tick();
    drive(30'h1, 3'd6, 3'd0, 1'b0, 3'd2, 1'b1, 16'h0033);
    stall_in = 1'b1;
    #1;
    chk("lu_rt_stall", 32'(stall_out), 32'(HZ));
    tick();
    chk("hold_ld_ctrl", 32'(ctrl_out), 32'h5);
    chk("hold_ld_rd1", 32'(rd1_out), 32'h44);
    chk("hold_stall", 32'(stall_out), 32'(HZ));
    flush_in = 1'b1;
    #1;
    chk("flush_kills_stall", 32'(stall_out), 32'd0);
    tick();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_ctrl", 32'(ctrl_out), 32'd0);
    chk("flush_rd1", 32'(rd1_out), 32'd0);
    flush_in = 1'b0; stall_in = 1'b0;

    // err + opaque bits pass through, then 3 held cycles, then flush+stall
    drive(30'h2000_0011, 3'd7, 3'd0, 1'b0, 3'd0, 1'b0, 16'hBEEF);
    rd2_in = 16'h1234; imm_in = 16'hFFFF; pc2_in = 16'h0200;
    tick();
    chk("err_ctrl", 32'(ctrl_out), 32'h2000_0011);
    chk("err_rd2", 32'(rd2_out), 32'h1234);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ctrl_in = 30'h21 + 30'(i);
      rd1_in  = 16'(i);
      tick();
      chk("hold_ctrl", 32'(ctrl_out), 32'h2000_0011);
      chk("hold_rd1", 32'(rd1_out), 32'hBEEF);
    end
    flush_in = 1'b1;
    tick();
    chk("fs_valid", 32'(ex_valid), 32'd0);
    chk("fs_ctrl", 32'(ctrl_out), 32'd0);
    chk("fs_imm", 32'(imm_out), 32'd0);
    flush_in = 1'b0; stall_in = 1'b0;

    // empty decode slot: control forced to 0, data still captured
    id_valid = 1'b0;
    drive(30'h5, 3'd4, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0042);
    tick();
    chk("inv_valid", 32'(ex_valid), 32'd0);
    chk("inv_ctrl", 32'(ctrl_out), 32'd0);
    chk("inv_dest", 32'(dest_out), 32'd4);
    chk("inv_rd1", 32'(rd1_out), 32'h42);
    id_valid = 1'b1;

    // HALT
    drive(30'h8, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0000);
    tick();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_ctrl", 32'(ctrl_out), 32'h8);
    chk("halt_valid", 32'(ex_valid), 32'd1);
    drive(30'h1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0005);
    tick();
    chk("halted_bubble_valid", 32'(ex_valid), 32'd0);
    chk("halted_bubble_ctrl", 32'(ctrl_out), 32'd0);
    flush_in = 1'b1;
    tick();
    chk("flush_keeps_halt", 32'(halted), 32'd1);
    flush_in = 1'b0;
    #3; rst_n = 1'b0; #1;
    chk("reset_clears_halt", 32'(halted), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_halt_capture", 32'(dest_out), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Pipeline register and load-use hazard detector between the decode stage (control decode plus register-file read) and the execute stage. It captures the decoded control bundle, operands, immediate and destination register on each clock. It inserts a bubble when execute holds a load whose destination matches a source register being read in decode. It also supports external stall (hold) and flush (squash), and freezes the pipeline front end once a HALT reaches execute.

## Interface
- `CTRL_W`, 30: control bundle width. Fixed bit meanings: [0] reg_write, [1] mem_write, [2] mem_read, [3] halt, [4] err, [5] jump, [8:6] branchSel. Remaining bits are opaque and passed through.
- `DATA_W`, 16: datapath width.
- `clk`  in  1  clock. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_in`  in  1  downstream stall: hold all registered state.
- `flush_in`  in  1  squash: load a bubble next edge.
- `id_valid`  in  1  decode slot holds a real instruction.
- `ctrl_in`  in  CTRL_W  decoded control bundle.
- `rs_in`, `rt_in`  in  3 each  source register numbers.
- `use_rs`, `use_rt`  in  1 each  instruction actually reads rs / rt.
- `dest_in`  in  3  resolved write register.
- `rd1_in`, `rd2_in`, `imm_in`, `pc2_in`  in  DATA_W each  operands, extended immediate, PC+2.
- `ex_valid`  out  1  execute slot holds a real instruction.
- `ctrl_out`  out  CTRL_W  registered control.
- `dest_out`  out  3  registered destination.
- `rd1_out`, `rd2_out`, `imm_out`, `pc2_out`  out  DATA_W each  registered operands.
- `stall_out`  out  1  combinational: hold PC and the IF/ID register this cycle.
- `halted`  out  1  sticky: a HALT has entered execute.

## Operation
- Bubble means: ex_valid=0, ctrl_out=0, all data outputs 0, dest_out=0.
- ex_load = ex_valid & ctrl_out[2] & ctrl_out[0] & ~ctrl_out[1]. Stores (mem_read without reg_write) and STU (mem_write set) are excluded.
- load_use = ex_load & id_valid & ((use_rs & rs_in==dest_out) | (use_rt & rt_in==dest_out)).
- stall_out = load_use & ~flush_in & ~halted.
- Next-state priority, highest first:
  1. reset
  2. flush_in: load a bubble
  3. stall_in: hold
  4. halted: load a bubble
  5. load_use: load a bubble
  6. otherwise: capture the inputs, with ex_valid = id_valid. If id_valid=0, ctrl is forced to 0.
- `halted` sets on the edge that captures a valid instruction with ctrl_in[3]=1. It clears only on reset; flush does not clear it.
- An instruction with err (bit 4) passes through unchanged; handling it is downstream's job.

## Timing
- Reset: all outputs 0 (bubble), halted=0, stall_out=0.
- Latency: 1 cycle from inputs to outputs.
- Load-use penalty: exactly one bubble. The cycle after the bubble, the dependent instruction is captured (its inputs were held upstream via stall_out).
- stall_in together with load_use: hold. stall_out stays high while the load remains in execute.
- flush_in together with stall_in: flush wins.
- flush_in together with load_use: bubble, and stall_out=0 so the squashed decode slot is not held.
- rst_n asserted mid-operation: outputs clear immediately (asynchronously). Release takes effect on the next clk edge.

## Configuration
- `ID_EX_HAZARD_EN` defined: load-use detection as specified above.
- Not defined: load_use is constant 0 and stall_out is tied 0. Hazards are then the compiler's or software's responsibility; all other behaviour is unchanged.

## Test plan
- Reset check: rst_n low at mid-cycle -> all outputs 0 immediately. Release, then drive ADDI (ctrl reg_write=1, dest=3, rd1=0x0005) -> next cycle ex_valid=1, dest_out=3, rd1_out=0x0005.
- Load-use on rs: LD to r2 (bits 0 and 2 set), then ADD with use_rs=1, rs=2 -> stall_out=1 for one cycle, one bubble inserted, ADD appears one cycle later.
- STU to r2 followed by reader of r2 -> stall_out=0, no bubble. Same for ST followed by a reader, and for use_rs=0.
- stall_in=1 for 3 cycles while ctrl_in changes -> outputs unchanged. Then flush_in together with stall_in -> bubble.
- HALT captured -> halted=1. Subsequent valid inputs produce bubbles (ex_valid=0). Flush leaves halted=1; reset clears it.
- Macro undefined: LD r2 then reader of r2 -> stall_out=0, reader captured back-to-back.
